mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute stage.
- Latches the execute stage's result bundle: pc, dest reg, write data, aluop, memory address, store data.
- Issues loads/stores on an SRAM-like data bus using a req/addr_ok/data_ok handshake, with one transaction outstanding at most.
- Aligns and extends load data, then hands a single result bundle to writeback under valid/allowin flow control.

Parameters:
- ALUOP_W, 8: width of aluop field, equal to `AluOpBus.
- ADDR_W, 32: address and data width, equal to `RegBus.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- ex_valid_i  in  1  execute bundle valid.
- mem_allowin_o  out  1  stage can accept a bundle this cycle.
- aluop_i  in  ALUOP_W  operation.
- inst_pc_i  in  32  pc.
- wd_i  in  5  dest reg.
- wreg_i  in  1  reg write enable.
- wdata_i  in  32  ALU result.
- mem_addr_i  in  32  effective address.
- reg2_i  in  32  store data.
- flush_i  in  1  kill the held bundle.
- data_req_o  out  1  bus request.
- data_wr_o  out  1  1 = store.
- data_size_o  out  2  0 = byte, 1 = half, 2 = word.
- data_wstrb_o  out  4  byte enables.
- data_addr_o  out  32  bus address.
- data_wdata_o  out  32  lane-replicated store data.
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  response / read data valid.
- data_rdata_i  in  32  read data.
- wb_allowin_i  in  1  writeback ready.
- wb_valid_o  out  1  result bundle valid.
- wb_pc_o  out  32  pc.
- wb_wd_o  out  5  dest reg.
- wb_wreg_o  out  1  reg write enable.
- wb_wdata_o  out  32  result.
- ale_o  out  1  misaligned-access exception.
- badv_o  out  32  faulting address.

Behaviour:
Reset:
- State IDLE; valid and all held fields cleared.
- All outputs 0, except mem_allowin_o = 1.

Accept:
- mem_allowin_o = !valid || (state==DONE && wb_allowin_i); forced 0 in CANCEL.
- A bundle latches on ex_valid_i && mem_allowin_o at the clock edge.
- Non-memory op: latches directly into DONE.
- Load/store: latches into REQ.

FSM (IDLE, REQ, WAIT, DONE, CANCEL):
- REQ: data_req_o = !flush_i; address, size, wstrb and wdata held stable. On data_addr_ok_i go to WAIT.
- WAIT: on data_data_ok_i go to DONE; for a load, the aligned/extended rdata is captured into wb_wdata_o.
- data_data_ok_i is ignored outside WAIT and CANCEL.
- DONE: wb_valid_o = 1. When wb_allowin_i is high the bundle retires: next state is IDLE, or REQ/DONE if a new bundle is accepted the same cycle (back-to-back).
- Latencies: ALU op reaches wb_valid_o 1 cycle after accept. Load with addr_ok in its first REQ cycle and data_ok the next cycle reaches wb_valid_o 3 cycles after accept.

Store lanes:
- ST.B: wstrb = 1<<addr[1:0]; wdata = {4{b}}.
- ST.H: wstrb = addr[1] ? 1100 : 0011; wdata = {2{h}}.
- ST.W: wstrb = 1111.
- Loads: wstrb = 0000.
- data_addr_o = full address.

Load extract:
- Shift rdata right by addr[1:0]*8.
- LD.B/LD.H sign-extend; LD.BU/LD.HU zero-extend; LD.W unchanged.

Flush (flush_i):
- In IDLE or DONE: valid cleared next cycle.
- In REQ without addr_ok that cycle: request dropped, go to IDLE.
- In REQ with addr_ok that same cycle, or in WAIT: go to CANCEL. CANCEL holds mem_allowin_o = 0 until data_data_ok_i, discards the response, then goes to IDLE.
- A flush in CANCEL has no further effect.
- Stores already past addr_ok are committed on the bus regardless of flush.

Reset mid-transaction: immediate return to IDLE; any outstanding response is the bus's responsibility.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: LD.H/ST.H with addr[0] = 1, or word access with addr[1:0] != 0, issues no request and latches into DONE with ale_o = 1, badv_o = addr, wb_wreg_o = 0.
- Undefined: no check; ale_o = 0 and badv_o = 0 constantly; low address bits are forced to 0 on data_addr_o for half and word accesses.

Decomposition:
- Shared package defines: the EXE_LD*/EXE_ST* aluop constants (same values as the execute stage), the mem-stage state encoding, and the size encoding.
- One sub-module, mem_align: combinational store-lane generation and load extract/extend, so it can be unit-tested separately.

Test Plan:
- ALU op (OR, wdata 0x1234) with wb_allowin_i = 1 -> wb_valid_o one cycle after accept, wdata 0x1234, data_req_o never asserted.
- LD.B at addr 0x1003 with rdata 0x80FF_FF00 -> wb_wdata_o = 0xFFFF_FF80. LD.BU at the same address -> 0x0000_0080.
- ST.H, addr 0x2002, reg2_i 0xABCD_5678, addr_ok delayed 3 cycles -> req held 4 cycles with stable signals: wstrb 1100, wdata 0x5678_5678, size 1.
- Flush in WAIT, then data_ok 2 cycles later -> mem_allowin_o = 0 until data_ok, no wb_valid_o, then IDLE.
- Back-to-back loads, each with addr_ok in its first REQ cycle and data_ok the next cycle -> one retire every 3 cycles, data in order. Also hold wb_allowin_i = 0 for 2 cycles in DONE -> outputs held stable.
- With MEM_ALIGN_CHECK_EN, LD.W at 0x3002 -> no data_req_o, ale_o = 1, badv_o = 0x3002, wb_wreg_o = 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: aluop constants, state and size encodings for the memory stage.
// Shared by mem_stage and mem_align (MEM_ALIGN_CHECK_EN consumers use misaligned()).
package mem_stage_pkg;

    localparam logic [7:0] EXE_OR_OP    = 8'h25;
    localparam logic [7:0] EXE_LD_B_OP  = 8'hE0;
    localparam logic [7:0] EXE_LD_H_OP  = 8'hE1;
    localparam logic [7:0] EXE_LD_W_OP  = 8'hE2;
    localparam logic [7:0] EXE_LD_BU_OP = 8'hE3;
    localparam logic [7:0] EXE_LD_HU_OP = 8'hE4;
    localparam logic [7:0] EXE_ST_B_OP  = 8'hE5;
    localparam logic [7:0] EXE_ST_H_OP  = 8'hE6;
    localparam logic [7:0] EXE_ST_W_OP  = 8'hE7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return op inside {EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP,
                          EXE_LD_BU_OP, EXE_LD_HU_OP};
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return op inside {EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
    endfunction

    function automatic mem_size_e op_size(input logic [7:0] op);
        mem_size_e sz;
        sz = SIZE_BYTE;
        if (op inside {EXE_LD_H_OP, EXE_LD_HU_OP, EXE_ST_H_OP})
            sz = SIZE_HALF;
        else if (op inside {EXE_LD_W_OP, EXE_ST_W_OP})
            sz = SIZE_WORD;
        return sz;
    endfunction

    function automatic logic misaligned(input logic [7:0] op,
                                        input logic [1:0] lo);
        mem_size_e sz;
        sz = op_size(op);
        return (sz == SIZE_HALF && lo[0]) ||
               (sz == SIZE_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: store byte-lane generation and load extract/extend.
// Purely combinational so it can be exercised on its own.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int ALUOP_W = 8
) (
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [31:0]        st_data,
    input  logic [31:0]        rdata,
    output logic [3:0]         wstrb,
    output logic [31:0]        wdata,
    output logic [31:0]        ld_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    // Byte enables and lane-replicated store data.
    always_comb begin
        wstrb = 4'b0000;
        wdata = st_data;
        case (aluop)
            EXE_ST_B_OP: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            EXE_ST_H_OP: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            EXE_ST_W_OP: wstrb = 4'b1111;
            default: ;
        endcase
    end

    // Select the addressed bytes and extend to a full word.
    always_comb begin
        ld_data = shifted;
        case (aluop)
            EXE_LD_B_OP:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            EXE_LD_BU_OP: ld_data = {24'h0, shifted[7:0]};
            EXE_LD_H_OP:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            EXE_LD_HU_OP: ld_data = {16'h0, shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage, one outstanding bus transaction.
// Optional misaligned-access exception with `define MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_valid_i,
    output logic               mem_allowin_o,
    input  logic [ALUOP_W-1:0] aluop_i,
    input  logic [ADDR_W-1:0]  inst_pc_i,
    input  logic [4:0]         wd_i,
    input  logic               wreg_i,
    input  logic [ADDR_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [ADDR_W-1:0]  reg2_i,
    input  logic               flush_i,
    output logic               data_req_o,
    output logic               data_wr_o,
    output logic [1:0]         data_size_o,
    output logic [3:0]         data_wstrb_o,
    output logic [ADDR_W-1:0]  data_addr_o,
    output logic [ADDR_W-1:0]  data_wdata_o,
    input  logic               data_addr_ok_i,
    input  logic               data_data_ok_i,
    input  logic [ADDR_W-1:0]  data_rdata_i,
    input  logic               wb_allowin_i,
    output logic               wb_valid_o,
    output logic [ADDR_W-1:0]  wb_pc_o,
    output logic [4:0]         wb_wd_o,
    output logic               wb_wreg_o,
    output logic [ADDR_W-1:0]  wb_wdata_o,
    output logic               ale_o,
    output logic [ADDR_W-1:0]  badv_o
);

    mem_state_e         state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  reg2_q;
    logic [ADDR_W-1:0]  wdata_q;
    logic [4:0]         wd_q;
    logic               wreg_q;
    logic               ale_q;
    logic [ALUOP_W-1:0] aluop_q;

    logic              accept;
    logic              in_mem;
    logic              in_ale;
    logic [ADDR_W-1:0] ld_data;

    mem_align #(
        .ALUOP_W (ALUOP_W)
    ) u_align (
        .aluop   (aluop_q),
        .addr_lo (addr_q[1:0]),
        .st_data (reg2_q),
        .rdata   (data_rdata_i),
        .wstrb   (data_wstrb_o),
        .wdata   (data_wdata_o),
        .ld_data (ld_data)
    );

    assign mem_allowin_o = (state_q == S_IDLE) ||
                           (state_q == S_DONE && wb_allowin_i);
    assign accept = ex_valid_i && mem_allowin_o;
    assign in_mem = is_load_op(aluop_i) || is_store_op(aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign in_ale      = in_mem && misaligned(aluop_i, mem_addr_i[1:0]);
    assign data_addr_o = addr_q;
`else
    assign in_ale = 1'b0;

    // Without the check, half/word accesses go out naturally aligned.
    always_comb begin
        data_addr_o = addr_q;
        case (op_size(aluop_q))
            SIZE_HALF: data_addr_o[0] = 1'b0;
            SIZE_WORD: data_addr_o[1:0] = 2'b00;
            default: ;
        endcase
    end
`endif

    assign data_req_o  = (state_q == S_REQ) && !flush_i;
    assign data_wr_o   = is_store_op(aluop_q);
    assign data_size_o = op_size(aluop_q);
    assign wb_valid_o  = (state_q == S_DONE);
    assign wb_pc_o     = pc_q;
    assign wb_wd_o     = wd_q;
    assign wb_wreg_o   = wreg_q;
    assign wb_wdata_o  = wdata_q;
    assign ale_o       = ale_q;
    assign badv_o      = ale_q ? addr_q : '0;

    // Stage FSM and held bundle; an accepted bundle overrides the retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            reg2_q  <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            ale_q   <= 1'b0;
            aluop_q <= '0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (flush_i)
                        state_q <= data_addr_ok_i ? S_CANCEL : S_IDLE;
                    else if (data_addr_ok_i)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (data_data_ok_i) begin
                        // Flushed in the response cycle: nothing left owed.
                        if (flush_i) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DONE;
                            if (is_load_op(aluop_q))
                                wdata_q <= ld_data;
                        end
                    end else if (flush_i) begin
                        state_q <= S_CANCEL;
                    end
                end
                S_DONE: begin
                    if (wb_allowin_i || flush_i)
                        state_q <= S_IDLE;
                end
                S_CANCEL: begin
                    if (data_data_ok_i)
                        state_q <= S_IDLE;
                end
                default: ;
            endcase
            if (accept) begin
                pc_q    <= inst_pc_i;
                addr_q  <= mem_addr_i;
                reg2_q  <= reg2_i;
                wdata_q <= wdata_i;
                wd_q    <= wd_i;
                wreg_q  <= wreg_i && !in_ale;
                ale_q   <= in_ale;
                aluop_q <= aluop_i;
                state_q <= (in_mem && !in_ale) ? S_REQ : S_DONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized self-checking bench for mem_stage.
// Expected values come from an arithmetic reference model of the stage rules.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic        mem_allowin_o;
    logic [7:0]  aluop_i;
    logic [31:0] inst_pc_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic        flush_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_allowin_i;
    logic        wb_valid_o;
    logic [31:0] wb_pc_o;
    logic [4:0]  wb_wd_o;
    logic        wb_wreg_o;
    logic [31:0] wb_wdata_o;
    logic        ale_o;
    logic [31:0] badv_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid_i     (ex_valid_i),
        .mem_allowin_o  (mem_allowin_o),
        .aluop_i        (aluop_i),
        .inst_pc_i      (inst_pc_i),
        .wd_i           (wd_i),
        .wreg_i         (wreg_i),
        .wdata_i        (wdata_i),
        .mem_addr_i     (mem_addr_i),
        .reg2_i         (reg2_i),
        .flush_i        (flush_i),
        .data_req_o     (data_req_o),
        .data_wr_o      (data_wr_o),
        .data_size_o    (data_size_o),
        .data_wstrb_o   (data_wstrb_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_addr_ok_i (data_addr_ok_i),
        .data_data_ok_i (data_data_ok_i),
        .data_rdata_i   (data_rdata_i),
        .wb_allowin_i   (wb_allowin_i),
        .wb_valid_o     (wb_valid_o),
        .wb_pc_o        (wb_pc_o),
        .wb_wd_o        (wb_wd_o),
        .wb_wreg_o      (wb_wreg_o),
        .wb_wdata_o     (wb_wdata_o),
        .ale_o          (ale_o),
        .badv_o         (badv_o)
    );

    // ---------------- reference model ----------------
    function automatic int ref_bytes(input logic [7:0] op);
        if (op == EXE_LD_H_OP || op == EXE_LD_HU_OP || op == EXE_ST_H_OP)
            return 2;
        if (op == EXE_LD_W_OP || op == EXE_ST_W_OP)
            return 4;
        return 1;
    endfunction

    function automatic logic [1:0] ref_size(input logic [7:0] op);
        int n;
        n = ref_bytes(op);
        return (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [7:0] op,
                                             input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a;
`else
        return a - (a % ref_bytes(op));
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] r;
        v = rd >> (8 * (a % 4));
        r = v;
        if (op == EXE_LD_B_OP) begin
            r = v % 256;
            if (r >= 128) r = r - 256;
        end else if (op == EXE_LD_BU_OP) begin
            r = v % 256;
        end else if (op == EXE_LD_H_OP) begin
            r = v % 65536;
            if (r >= 32768) r = r - 65536;
        end else if (op == EXE_LD_HU_OP) begin
            r = v % 65536;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [7:0] op,
                                             input logic [31:0] a);
        if (op == EXE_ST_B_OP) return 4'(1 << (a % 4));
        if (op == EXE_ST_H_OP) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        if (op == EXE_ST_W_OP) return 4'd15;
        return 4'd0;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op,
                                              input logic [31:0] d);
        if (op == EXE_ST_B_OP) return (d % 256) * 32'h0101_0101;
        if (op == EXE_ST_H_OP) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic present(input logic [7:0] op, input logic [31:0] pc,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] r2, input logic [4:0] rd,
                           input logic we);
        ex_valid_i = 1'b1;
        aluop_i    = op;
        inst_pc_i  = pc;
        mem_addr_i = addr;
        wdata_i    = wd;
        reg2_i     = r2;
        wd_i       = rd;
        wreg_i     = we;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_allowin_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_allowin got=%b exp=1", mem_allowin_o);
        end
        checks++;
        if ({wb_valid_o, data_req_o, data_wr_o, ale_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {wb_valid_o, data_req_o, data_wr_o, ale_o});
        end
        checks++;
        if ({wb_pc_o, wb_wdata_o, badv_o, data_addr_o} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data pc=%h wd=%h badv=%h addr=%h exp=0",
                     wb_pc_o, wb_wdata_o, badv_o, data_addr_o);
        end
        checks++;
        if ({data_wstrb_o, data_size_o, wb_wd_o, wb_wreg_o} !== 12'h0) begin
            errors++;
            $display("FAIL reset_ctrl wstrb=%b size=%0d wd=%0d wreg=%b exp=0",
                     data_wstrb_o, data_size_o, wb_wd_o, wb_wreg_o);
        end
        tick;
    endtask

    task automatic test_alu;
        logic [31:0] wd;
        logic [31:0] pc;
        logic [4:0]  rd;
        for (int i = 0; i < 5; i++) begin
            wd = (i == 0) ? 32'h1234 : $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            rd = 5'($urandom_range(1, 31));
            present(EXE_OR_OP, pc, $urandom, wd, $urandom, rd, 1'b1);
            #1;
            checks++;
            if (mem_allowin_o !== 1'b1) begin
                errors++;
                $display("FAIL alu_allowin[%0d] got=%b exp=1", i, mem_allowin_o);
            end
            tick;
            ex_valid_i = 1'b0;
            #1;
            checks++;
            if (wb_valid_o !== 1'b1 || data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL alu_lat[%0d] valid=%b req=%b exp valid=1 req=0",
                         i, wb_valid_o, data_req_o);
            end
            checks++;
            if (wb_wdata_o !== wd || wb_pc_o !== pc ||
                wb_wd_o !== rd || wb_wreg_o !== 1'b1) begin
                errors++;
                $display("FAIL alu_data[%0d] got=%h/%h/%0d/%b exp=%h/%h/%0d/1",
                         i, wb_wdata_o, wb_pc_o, wb_wd_o, wb_wreg_o, wd, pc, rd);
            end
            tick;
            #1;
            checks++;
            if (wb_valid_o !== 1'b0 || data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL alu_retire[%0d] valid=%b req=%b exp=0",
                         i, wb_valid_o, data_req_o);
            end
            tick;
        end
    endtask

    task automatic test_load;
        logic [7:0]  ops [5];
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] rd;
        logic [31:0] exp;
        ops = '{EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP,
                EXE_LD_BU_OP, EXE_LD_HU_OP};
        for (int i = 0; i < 18; i++) begin
            if (i < 2) begin
                op = (i == 0) ? EXE_LD_B_OP : EXE_LD_BU_OP;
                a  = 32'h1003;
                rd = 32'h80FF_FF00;
            end else begin
                op = ops[$urandom_range(0, 4)];
                a  = $urandom;
                a  = a - (a % ref_bytes(op));
                rd = $urandom;
            end
            exp = ref_load(op, a, rd);
            if (i == 0) begin
                checks++;
                if (exp !== 32'hFFFF_FF80) begin
                    errors++;
                    $display("FAIL model_ldb got=%h exp=ffffff80", exp);
                end
            end
            present(op, 32'h1c00_1000 + i * 4, a, $urandom, $urandom,
                    5'd7, 1'b1);
            tick;
            ex_valid_i     = 1'b0;
            data_addr_ok_i = 1'b1;
            #1;
            checks++;
            if (data_req_o !== 1'b1 || data_wr_o !== 1'b0 ||
                data_wstrb_o !== 4'b0000 || mem_allowin_o !== 1'b0) begin
                errors++;
                $display("FAIL ld_req[%0d] req=%b wr=%b wstrb=%b allow=%b",
                         i, data_req_o, data_wr_o, data_wstrb_o, mem_allowin_o);
            end
            checks++;
            if (data_addr_o !== ref_addr(op, a) ||
                data_size_o !== ref_size(op)) begin
                errors++;
                $display("FAIL ld_bus[%0d] addr=%h size=%0d exp=%h/%0d", i,
                         data_addr_o, data_size_o, ref_addr(op, a), ref_size(op));
            end
            tick;
            data_addr_ok_i = 1'b0;
            data_data_ok_i = 1'b1;
            data_rdata_i   = rd;
            #1;
            checks++;
            if (wb_valid_o !== 1'b0 || data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL ld_wait[%0d] valid=%b req=%b exp=0",
                         i, wb_valid_o, data_req_o);
            end
            tick;
            data_data_ok_i = 1'b0;
            data_rdata_i   = $urandom;
            #1;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_wdata_o !== exp || ale_o !== 1'b0) begin
                errors++;
                $display("FAIL ld_data[%0d] op=%h a=%h valid=%b got=%h exp=%h",
                         i, op, a, wb_valid_o, wb_wdata_o, exp);
            end
            if (i == 1) begin
                checks++;
                if (wb_wdata_o !== 32'h0000_0080) begin
                    errors++;
                    $display("FAIL ld_bu got=%h exp=00000080", wb_wdata_o);
                end
            end
            tick;
        end
    endtask

    task automatic test_store;
        logic [7:0]  ops [3];
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          dly;
        ops = '{EXE_ST_B_OP, EXE_ST_H_OP, EXE_ST_W_OP};
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                op  = EXE_ST_H_OP;
                a   = 32'h2002;
                d   = 32'hABCD_5678;
                dly = 3;
            end else begin
                op  = ops[$urandom_range(0, 2)];
                a   = $urandom;
                a   = a - (a % ref_bytes(op));
                d   = $urandom;
                dly = $urandom_range(0, 2);
            end
            present(op, 32'h1c00_2000 + i * 4, a, a, d, 5'd0, 1'b0);
            tick;
            ex_valid_i = 1'b0;
            for (int c = 0; c <= dly; c++) begin
                data_addr_ok_i = (c == dly);
                #1;
                checks++;
                if (data_req_o !== 1'b1 || data_wr_o !== 1'b1 ||
                    data_size_o !== ref_size(op) ||
                    data_addr_o !== ref_addr(op, a)) begin
                    errors++;
                    $display("FAIL st_req[%0d.%0d] req=%b wr=%b size=%0d addr=%h exp addr=%h",
                             i, c, data_req_o, data_wr_o, data_size_o,
                             data_addr_o, ref_addr(op, a));
                end
                checks++;
                if (data_wstrb_o !== ref_wstrb(op, a) ||
                    data_wdata_o !== ref_wdata(op, d)) begin
                    errors++;
                    $display("FAIL st_lane[%0d.%0d] wstrb=%b wdata=%h exp=%b/%h",
                             i, c, data_wstrb_o, data_wdata_o,
                             ref_wstrb(op, a), ref_wdata(op, d));
                end
                tick;
            end
            data_addr_ok_i = 1'b0;
            data_data_ok_i = 1'b1;
            #1;
            checks++;
            if (data_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL st_wait[%0d] req=%b valid=%b exp=0",
                         i, data_req_o, wb_valid_o);
            end
            tick;
            data_data_ok_i = 1'b0;
            #1;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_wreg_o !== 1'b0 || wb_wdata_o !== a) begin
                errors++;
                $display("FAIL st_done[%0d] valid=%b wreg=%b wdata=%h exp 1/0/%h",
                         i, wb_valid_o, wb_wreg_o, wb_wdata_o, a);
            end
            tick;
        end
    endtask

    task automatic test_flush;
        // flush while waiting for data; response 2 cycles later
        present(EXE_LD_W_OP, 32'h1c00_3000, 32'h5000, 0, 0, 5'd4, 1'b1);
        tick;
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b1;
        tick;
        data_addr_ok_i = 1'b0;
        flush_i        = 1'b1;
        #1;
        checks++;
        if (mem_allowin_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_wait_allow got=%b exp=0", mem_allowin_o);
        end
        tick;
        flush_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_data_ok_i = (c == 1);
            data_rdata_i   = $urandom;
            #1;
            checks++;
            if (mem_allowin_o !== 1'b0 || wb_valid_o !== 1'b0 ||
                data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL fl_cancel[%0d] allow=%b valid=%b req=%b exp=0",
                         c, mem_allowin_o, wb_valid_o, data_req_o);
            end
            tick;
        end
        data_data_ok_i = 1'b0;
        #1;
        checks++;
        if (mem_allowin_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_idle allow=%b valid=%b exp 1/0",
                     mem_allowin_o, wb_valid_o);
        end
        // flush in REQ before the address is accepted
        present(EXE_LD_B_OP, 32'h1c00_3004, 32'h5001, 0, 0, 5'd4, 1'b1);
        tick;
        ex_valid_i = 1'b0;
        flush_i    = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_req_drop got=%b exp=0", data_req_o);
        end
        tick;
        flush_i = 1'b0;
        #1;
        checks++;
        if (mem_allowin_o !== 1'b1 || wb_valid_o !== 1'b0 || data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL fl_req_idle allow=%b valid=%b req=%b exp 1/0/0",
                     mem_allowin_o, wb_valid_o, data_req_o);
        end
        // flush a completed bundle held by a stalled writeback
        wb_allowin_i = 1'b0;
        present(EXE_OR_OP, 32'h1c00_3008, 0, 32'h77, 0, 5'd5, 1'b1);
        tick;
        ex_valid_i = 1'b0;
        flush_i    = 1'b1;
        tick;
        flush_i = 1'b0;
        #1;
        checks++;
        if (wb_valid_o !== 1'b0 || mem_allowin_o !== 1'b1) begin
            errors++;
            $display("FAIL fl_done valid=%b allow=%b exp 0/1",
                     wb_valid_o, mem_allowin_o);
        end
        wb_allowin_i = 1'b1;
        tick;
    endtask

    task automatic test_back_to_back;
        localparam int N = 4;
        logic [7:0]  ops [5];
        logic [7:0]  op [N];
        logic [31:0] ad [N];
        logic [31:0] rd [N];
        logic [31:0] r;
        int acc = 0;
        int iss = 0;
        int ret = 0;
        int last = 0;
        int pend_idx = 0;
        logic pend = 1'b0;
        ops = '{EXE_LD_B_OP, EXE_LD_H_OP, EXE_LD_W_OP,
                EXE_LD_BU_OP, EXE_LD_HU_OP};
        for (int k = 0; k < N; k++) begin
            op[k] = ops[$urandom_range(0, 4)];
            r     = $urandom;
            ad[k] = r - (r % ref_bytes(op[k]));
            rd[k] = $urandom;
        end
        for (int cyc = 0; cyc < 40 && ret < N; cyc++) begin
            if (acc < N)
                present(op[acc], 32'h8000 + acc * 4, ad[acc], 0, 0,
                        5'(acc + 1), 1'b1);
            else
                ex_valid_i = 1'b0;
            data_data_ok_i = pend;
            data_rdata_i   = pend ? rd[pend_idx] : $urandom;
            #1;
            data_addr_ok_i = data_req_o;
            #1;
            if (wb_valid_o && wb_allowin_i) begin
                checks++;
                if (wb_wdata_o !== ref_load(op[ret], ad[ret], rd[ret]) ||
                    wb_pc_o !== 32'h8000 + ret * 4) begin
                    errors++;
                    $display("FAIL b2b_data[%0d] got=%h pc=%h exp=%h pc=%h", ret,
                             wb_wdata_o, wb_pc_o,
                             ref_load(op[ret], ad[ret], rd[ret]),
                             32'h8000 + ret * 4);
                end
                if (ret > 0) begin
                    checks++;
                    if (cyc - last != 3) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d] got=%0d exp=3",
                                 ret, cyc - last);
                    end
                end
                last = cyc;
                ret++;
            end
            pend = 1'b0;
            if (data_req_o && data_addr_ok_i) begin
                pend     = 1'b1;
                pend_idx = iss;
                iss++;
            end
            if (ex_valid_i && mem_allowin_o)
                acc++;
            tick;
        end
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        checks++;
        if (ret != N) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=%0d", ret, N);
        end
        // writeback stall holds the result steady
        r = $urandom;
        present(EXE_LD_W_OP, 32'h9000, 32'h4000, 0, 0, 5'd9, 1'b1);
        tick;
        ex_valid_i     = 1'b0;
        data_addr_ok_i = 1'b1;
        tick;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1;
        data_rdata_i   = r;
        tick;
        data_data_ok_i = 1'b0;
        wb_allowin_i   = 1'b0;
        for (int c = 0; c < 2; c++) begin
            data_rdata_i = $urandom;
            #1;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_wdata_o !== r ||
                wb_pc_o !== 32'h9000 || mem_allowin_o !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d] valid=%b wdata=%h pc=%h allow=%b exp 1/%h/9000/0",
                         c, wb_valid_o, wb_wdata_o, wb_pc_o, mem_allowin_o, r);
            end
            tick;
        end
        wb_allowin_i = 1'b1;
        #1;
        checks++;
        if (wb_valid_o !== 1'b1 || mem_allowin_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release valid=%b allow=%b exp 1/1",
                     wb_valid_o, mem_allowin_o);
        end
        tick;
        #1;
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_retire valid=%b exp=0", wb_valid_o);
        end
        tick;
    endtask

    task automatic test_align;
        logic [31:0] r;
        r = $urandom;
        present(EXE_LD_W_OP, 32'h1c00_4000, 32'h3002, 0, 0, 5'd6, 1'b1);
        tick;
        ex_valid_i = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        data_addr_ok_i = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b0 || wb_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ale_flow req=%b valid=%b exp 0/1", data_req_o, wb_valid_o);
        end
        checks++;
        if (ale_o !== 1'b1 || badv_o !== 32'h3002 || wb_wreg_o !== 1'b0) begin
            errors++;
            $display("FAIL ale_info ale=%b badv=%h wreg=%b exp 1/3002/0",
                     ale_o, badv_o, wb_wreg_o);
        end
        data_addr_ok_i = 1'b0;
        tick;
`else
        data_addr_ok_i = 1'b1;
        #1;
        checks++;
        if (data_req_o !== 1'b1 || data_addr_o !== 32'h3000) begin
            errors++;
            $display("FAIL noale_req req=%b addr=%h exp 1/3000", data_req_o, data_addr_o);
        end
        tick;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b1;
        data_rdata_i   = r;
        tick;
        data_data_ok_i = 1'b0;
        #1;
        checks++;
        if (ale_o !== 1'b0 || badv_o !== 32'h0 || wb_wreg_o !== 1'b1 ||
            wb_wdata_o !== ref_load(EXE_LD_W_OP, 32'h3002, r)) begin
            errors++;
            $display("FAIL noale_done ale=%b badv=%h wreg=%b wdata=%h exp 0/0/1/%h",
                     ale_o, badv_o, wb_wreg_o, wb_wdata_o,
                     ref_load(EXE_LD_W_OP, 32'h3002, r));
        end
        tick;
`endif
    endtask

    initial begin
        rst            = 1'b1;
        ex_valid_i     = 1'b0;
        aluop_i        = '0;
        inst_pc_i      = '0;
        wd_i           = '0;
        wreg_i         = 1'b0;
        wdata_i        = '0;
        mem_addr_i     = '0;
        reg2_i         = '0;
        flush_i        = 1'b0;
        data_addr_ok_i = 1'b0;
        data_data_ok_i = 1'b0;
        data_rdata_i   = '0;
        wb_allowin_i   = 1'b1;
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_flush;
        test_back_to_back;
        test_align;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
